// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared types and default 800x600@72 timing for the VGA beam
//                sequencer and its axis counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

   // Raster phase of one axis; the order follows the scan order of a line/frame
   typedef enum logic [1:0] {
      ACT  = 2'd0,
      FP   = 2'd1,
      SYNC = 2'd2,
      BP   = 2'd3
   } vga_phase_t;

   typedef logic [10:0] beam_x_t;
   typedef logic [9:0]  beam_y_t;

   // Default 800x600@72 timing (50 MHz pixel clock)
   localparam int C_H_VISIBLE = 800;
   localparam int C_H_FRONT   = 56;
   localparam int C_H_SYNC    = 120;
   localparam int C_H_BACK    = 64;
   localparam int C_V_VISIBLE = 600;
   localparam int C_V_FRONT   = 37;
   localparam int C_V_SYNC    = 6;
   localparam int C_V_BACK    = 23;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_beam_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_beam_sequencer_if
//  Description : Beam/sync bundle between the raster sequencer (master) and
//                the painter / DAC side (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_beam_sequencer_if;
   import vga_pkg::*;

   logic    pix_en;
   beam_x_t beam_x;
   beam_y_t beam_y;
   logic    draw;
   logic    hsync;
   logic    vsync;
   logic    frame_start;
   logic    vblank;

   modport master (
      input  pix_en,
      output beam_x, beam_y, draw, hsync, vsync, frame_start, vblank
   );

   modport slave (
      output pix_en,
      input  beam_x, beam_y, draw, hsync, vsync, frame_start, vblank
   );

endinterface : vga_beam_sequencer_if
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_counter
//  Description : Position counter plus ACT/FP/SYNC/BP phase FSM for one
//                raster axis. Advances on step_i, wraps after the back porch.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
   parameter int VISIBLE = 800,
   parameter int FRONT   = 56,
   parameter int SYNC    = 120,
   parameter int BACK    = 64,
   parameter int WIDTH   = 11
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   input  wire logic               step_i,
   output logic [WIDTH-1:0]        count_o,
   output vga_pkg::vga_phase_t     phase_nxt_o,
   output logic                    wrap_o
);
   import vga_pkg::*;

   localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

   // Last position of each phase; the phase changes on the step leaving it
   localparam logic [WIDTH-1:0] C_ACT_END  = WIDTH'(VISIBLE - 1);
   localparam logic [WIDTH-1:0] C_FP_END   = WIDTH'(VISIBLE + FRONT - 1);
   localparam logic [WIDTH-1:0] C_SYNC_END = WIDTH'(VISIBLE + FRONT + SYNC - 1);
   localparam logic [WIDTH-1:0] C_LAST     = WIDTH'(TOTAL - 1);

   // Each phase must be at least one position long for the FSM to visit it
   if (VISIBLE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_chk_phases
      $error("vga_axis_counter: every phase needs a length of at least 1");
   end

   if (TOTAL > (1 << WIDTH)) begin : g_chk_width
      $error("vga_axis_counter: TOTAL does not fit in WIDTH bits");
   end

   logic [WIDTH-1:0]     count_q, count_d;
   vga_pkg::vga_phase_t  phase_q, phase_d;

   // State register: position and phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         phase_q <= vga_pkg::ACT;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
      end
   end

   // Next state: increment with wrap, phase advances on its last position
   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      if (step_i) begin
         if (count_q == C_LAST) begin
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
         case (phase_q)
            vga_pkg::ACT:  if (count_q == C_ACT_END)  phase_d = vga_pkg::FP;
            vga_pkg::FP:   if (count_q == C_FP_END)   phase_d = vga_pkg::SYNC;
            vga_pkg::SYNC: if (count_q == C_SYNC_END) phase_d = vga_pkg::BP;
            vga_pkg::BP:   if (count_q == C_LAST)     phase_d = vga_pkg::ACT;
            default:                                  phase_d = vga_pkg::ACT;
         endcase
      end
   end

   // Outputs: current position, upcoming phase and the wrap strobe
   always_comb begin
      count_o     = count_q;
      phase_nxt_o = phase_d;
      wrap_o      = step_i && (count_q == C_LAST);
   end

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_beam_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_beam_sequencer
//  Description : VGA raster timing generator. Drives beam position, draw,
//                hsync/vsync, frame_start and vblank from two axis counters.
//                Optional macro VGA_SYNC_ALIGN_EN delays hsync/vsync by
//                PAINTER_LAT cycles to match a registered painter pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_beam_sequencer #(
   parameter int H_VISIBLE   = vga_pkg::C_H_VISIBLE,
   parameter int H_FRONT     = vga_pkg::C_H_FRONT,
   parameter int H_SYNC      = vga_pkg::C_H_SYNC,
   parameter int H_BACK      = vga_pkg::C_H_BACK,
   parameter int V_VISIBLE   = vga_pkg::C_V_VISIBLE,
   parameter int V_FRONT     = vga_pkg::C_V_FRONT,
   parameter int V_SYNC      = vga_pkg::C_V_SYNC,
   parameter int V_BACK      = vga_pkg::C_V_BACK,
   parameter bit SYNC_ACTIVE = 1'b1,
   parameter int PAINTER_LAT = 1
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   vga_beam_sequencer_if.master   bus
);
   import vga_pkg::*;

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic C_SYNC_ON  = SYNC_ACTIVE;
   localparam logic C_SYNC_OFF = ~SYNC_ACTIVE;

   if (H_TOTAL > 2048) begin : g_chk_htotal
      $error("vga_beam_sequencer: H_TOTAL exceeds 11-bit beam_x range");
   end

   if (V_TOTAL > 1024) begin : g_chk_vtotal
      $error("vga_beam_sequencer: V_TOTAL exceeds 10-bit beam_y range");
   end

   if (PAINTER_LAT < 1) begin : g_chk_lat
      $error("vga_beam_sequencer: PAINTER_LAT must be at least 1");
   end

   // Reset acts as a frame boundary: the first enabled cycle presents (0,0)
   // with frame_start, and only later enabled cycles move the beam.
   logic        primed_q;
   logic        h_step, v_step, h_wrap, v_wrap;
   vga_phase_t  h_nxt, v_nxt;
   beam_x_t     h_cnt;
   beam_y_t     v_cnt;

   logic        draw_q, hsync_q, vsync_q, vblank_q, frame_start_q;

   assign h_step = bus.pix_en & primed_q;
   assign v_step = h_wrap & bus.pix_en;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .WIDTH   ($bits(beam_x_t))
   ) u_h_axis (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_i      (h_step),
      .count_o     (h_cnt),
      .phase_nxt_o (h_nxt),
      .wrap_o      (h_wrap)
   );

   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .WIDTH   ($bits(beam_y_t))
   ) u_v_axis (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_i      (v_step),
      .count_o     (v_cnt),
      .phase_nxt_o (v_nxt),
      .wrap_o      (v_wrap)
   );

   // Registered status outputs follow the phases the counters move into
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         primed_q      <= 1'b0;
         draw_q        <= 1'b0;
         hsync_q       <= C_SYNC_OFF;
         vsync_q       <= C_SYNC_OFF;
         vblank_q      <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= bus.pix_en & (~primed_q | v_wrap);
         if (bus.pix_en) begin
            primed_q <= 1'b1;
            draw_q   <= (h_nxt == ACT) && (v_nxt == ACT);
            hsync_q  <= (h_nxt == SYNC) ? C_SYNC_ON : C_SYNC_OFF;
            vsync_q  <= (v_nxt == SYNC) ? C_SYNC_ON : C_SYNC_OFF;
            vblank_q <= (v_nxt != ACT);
         end
      end
   end

`ifdef VGA_SYNC_ALIGN_EN
   logic [PAINTER_LAT-1:0] hs_pipe_q, vs_pipe_q;

   // Delay the syncs to line up with the painter's registered RGB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_pipe_q <= {PAINTER_LAT{C_SYNC_OFF}};
         vs_pipe_q <= {PAINTER_LAT{C_SYNC_OFF}};
      end else begin
         hs_pipe_q[0] <= hsync_q;
         vs_pipe_q[0] <= vsync_q;
         for (int i = 1; i < PAINTER_LAT; i++) begin
            hs_pipe_q[i] <= hs_pipe_q[i-1];
            vs_pipe_q[i] <= vs_pipe_q[i-1];
         end
      end
   end

   assign bus.hsync = hs_pipe_q[PAINTER_LAT-1];
   assign bus.vsync = vs_pipe_q[PAINTER_LAT-1];
`else
   assign bus.hsync = hsync_q;
   assign bus.vsync = vsync_q;
`endif

   assign bus.beam_x      = h_cnt;
   assign bus.beam_y      = v_cnt;
   assign bus.draw        = draw_q;
   assign bus.vblank      = vblank_q;
   assign bus.frame_start = frame_start_q;

endmodule : vga_beam_sequencer
`default_nettype wire
